// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: sequences one UART_RX (enable, divisor) and buffers bytes.
// Define UART_RX_CTRL_IRQ_EN to build the threshold/overrun interrupt.
module uart_rx_ctrl #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_i,
  input  logic        rd_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        rd_valid_o,
  output logic        irq_o,
  input  logic        uart_rxd_i,
  output logic        rx_en_o,
  output logic        wr_bit_period_o,
  output logic [15:0] bit_period_o,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_parity_error_i
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [15:0] RST_DIV = 16'(CLK_FREQ / BAUD_RATE);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_DISABLED,
    S_RUN,
    S_DRAIN,
    S_PROGRAM,
    S_RESUME
  } state_t;

  state_t state, state_n;

  logic          en;
  logic [15:0]   pending;
  logic [15:0]   bp_q;
  logic          repend;
  logic [16:0]   quiet_cnt;
  logic [16:0]   quiet_inc;
  logic [16:0]   quiet_tgt;
  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic          overrun, parity_seen;
  logic          rx_valid_q;
  logic          wr_stat, wr_ctrl, wr_div, rd_data;
  logic          flush, empty, full, push, pop, do_push, busy;
  logic [15:0]   div_val;
  logic [31:0]   status_rd, ctrl_rd;
  logic          unused;

  assign unused  = ^wdata_i[31:16];
  assign wr_stat = wr_i && (addr_i == 2'd1);
  assign wr_ctrl = wr_i && (addr_i == 2'd2);
  assign wr_div  = wr_i && (addr_i == 2'd3);
  assign rd_data = rd_i && (addr_i == 2'd0);
  assign flush   = wr_ctrl && wdata_i[2];
  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign push    = rx_valid_i && !rx_valid_q;
  assign pop     = rd_data && !empty;
  assign do_push = push && (!full || pop) && !flush;
  assign busy    = (state == S_DRAIN) || (state == S_PROGRAM) ||
                   (state == S_RESUME);
  assign div_val = (wdata_i[15:0] < 16'd4) ? 16'd4 : wdata_i[15:0];

  assign quiet_inc = quiet_cnt + 17'd1;
  assign quiet_tgt = {bp_q, 1'b0};

  assign rx_en_o         = (state == S_RUN) || (state == S_DRAIN);
  assign wr_bit_period_o = (state == S_PROGRAM);
  // Present the new divisor during the programming strobe itself.
  assign bit_period_o    = wr_bit_period_o ? pending : bp_q;

  always_comb begin
    state_n = state;
    unique case (state)
      S_DISABLED: begin
        if (wr_ctrl && wdata_i[0]) state_n = S_RUN;
        else if (wr_div)           state_n = S_PROGRAM;
      end
      S_RUN: begin
        if (wr_ctrl && !wdata_i[0]) state_n = S_DISABLED;
        else if (wr_div)            state_n = S_DRAIN;
      end
      S_DRAIN: begin
        if (wr_ctrl && !wdata_i[0]) state_n = S_PROGRAM;
        else if (uart_rxd_i && quiet_inc >= quiet_tgt)
          state_n = S_PROGRAM;
      end
      S_PROGRAM: state_n = S_RESUME;
      S_RESUME: begin
        if (repend || wr_div) state_n = S_DRAIN;
        else if (en)          state_n = S_RUN;
        else                  state_n = S_DISABLED;
      end
      default: state_n = S_DISABLED;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_DISABLED;
      en        <= 1'b0;
      pending   <= RST_DIV;
      bp_q      <= RST_DIV;
      repend    <= 1'b0;
      quiet_cnt <= '0;
    end else begin
      state <= state_n;
      if (wr_ctrl) en <= wdata_i[0];
      if (wr_div) pending <= div_val;
      if (state == S_PROGRAM) bp_q <= pending;
      if (state == S_RESUME) repend <= 1'b0;
      else if (wr_div && state == S_PROGRAM) repend <= 1'b1;
      if (state_n == S_DRAIN && state != S_DRAIN) quiet_cnt <= '0;
      else if (state == S_DRAIN) quiet_cnt <= uart_rxd_i ? quiet_inc : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= {rx_parity_error_i, rx_data_i};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      overrun     <= 1'b0;
      parity_seen <= 1'b0;
      rx_valid_q  <= 1'b0;
    end else begin
      rx_valid_q <= rx_valid_i;
      if (flush) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else begin
        if (do_push) wptr <= wptr + 1'b1;
        if (pop) rptr <= rptr + 1'b1;
        count <= count + CW'(do_push) - CW'(pop);
      end
      // A new event outranks a clear arriving in the same cycle.
      if (wr_stat && wdata_i[2]) overrun <= 1'b0;
      if (push && full && !pop && !flush) overrun <= 1'b1;
      if (wr_stat && wdata_i[3]) parity_seen <= 1'b0;
      if (do_push && rx_parity_error_i) parity_seen <= 1'b1;
    end
  end

  always_comb begin
    status_rd = 32'd0;
    status_rd[4:0] = {busy, parity_seen, overrun, full, empty};
    status_rd[8 +: CW] = count;
  end

`ifdef UART_RX_CTRL_IRQ_EN
  logic       irq_en_q;
  logic [3:0] irq_thr;
  logic [3:0] thr_eff;
  logic       irq_hit;

  assign thr_eff = (irq_thr == 4'd0) ? 4'd1 : irq_thr;
  assign irq_hit = (32'(count) >= 32'(thr_eff)) || overrun;
  assign ctrl_rd = {20'd0, irq_thr, 6'd0, irq_en_q, en};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_en_q <= 1'b0;
      irq_thr  <= 4'd0;
      irq_o    <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        irq_en_q <= wdata_i[1];
        irq_thr  <= wdata_i[11:8];
      end
      irq_o <= irq_en_q && irq_hit;
    end
  end
`else
  assign ctrl_rd = {31'd0, en};
  assign irq_o   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_o    <= 32'd0;
      rd_valid_o <= 1'b0;
    end else begin
      rd_valid_o <= rd_i;
      if (rd_i) begin
        unique case (addr_i)
          2'd0: rdata_o <= empty ? 32'h8000_0000 : {23'd0, mem[rptr]};
          2'd1: rdata_o <= status_rd;
          2'd2: rdata_o <= ctrl_rd;
          2'd3: rdata_o <= {16'd0, pending};
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed stimulus with a read-data scoreboard.
// Expected register reads are queued; a monitor checks them on rd_valid_o.
module tb_uart_rx_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        wr_i, rd_i;
  logic [1:0]  addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        rd_valid_o, irq_o;
  logic        uart_rxd_i;
  logic        rx_en_o, wr_bit_period_o;
  logic [15:0] bit_period_o;
  logic        rx_valid_i;
  logic [7:0]  rx_data_i;
  logic        rx_parity_error_i;

  int checks = 0;
  int failures = 0;
  int rd_idx = 0;
  logic [31:0] exp_q[$];

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_STAT = 2'd1;
  localparam logic [1:0] A_CTRL = 2'd2;
  localparam logic [1:0] A_DIV  = 2'd3;

  uart_rx_ctrl dut (
    .clk(clk), .rst(rst), .wr_i(wr_i), .rd_i(rd_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .rdata_o(rdata_o), .rd_valid_o(rd_valid_o),
    .irq_o(irq_o), .uart_rxd_i(uart_rxd_i), .rx_en_o(rx_en_o),
    .wr_bit_period_o(wr_bit_period_o), .bit_period_o(bit_period_o),
    .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i),
    .rx_parity_error_i(rx_parity_error_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rd_valid_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd_unexpected actual=%h expected=none", rdata_o);
      end else begin
        check($sformatf("rd_%0d", rd_idx), rdata_o, exp_q.pop_front());
      end
      rd_idx++;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic host_wr(input logic [1:0] a, input logic [31:0] d);
    wr_i = 1'b1;
    addr_i = a;
    wdata_i = d;
    tick();
    wr_i = 1'b0;
  endtask

  task automatic host_rd(input logic [1:0] a, input logic [31:0] e);
    rd_i = 1'b1;
    addr_i = a;
    exp_q.push_back(e);
    tick();
    rd_i = 1'b0;
  endtask

  task automatic rx_byte(input logic [7:0] d, input logic pe);
    rx_data_i = d;
    rx_parity_error_i = pe;
    rx_valid_i = 1'b1;
    tick();
    rx_valid_i = 1'b0;
    tick();
  endtask

  task automatic wait_pulse(output int n, output logic [15:0] bp);
    n = -1;
    bp = '0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (wr_bit_period_o) begin
        n = i;
        bp = bit_period_o;
        break;
      end
    end
  endtask

  initial begin
    int n;
    logic [15:0] bp;
    int bad;
    rst = 1'b1;
    wr_i = 1'b0;
    rd_i = 1'b0;
    addr_i = '0;
    wdata_i = '0;
    uart_rxd_i = 1'b1;
    rx_valid_i = 1'b0;
    rx_data_i = '0;
    rx_parity_error_i = 1'b0;
    tick(3);
    rst = 1'b0;

    // reset in the middle of a drain
    host_wr(A_CTRL, 32'h1);
    host_wr(A_DIV, 32'h100);
    uart_rxd_i = 1'b0;
    tick(5);
    check("drain_rx_en", 32'(rx_en_o), 32'd1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst_rx_en", 32'(rx_en_o), 32'd0);
    check("rst_wr_bp", 32'(wr_bit_period_o), 32'd0);
    check("rst_bp", 32'(bit_period_o), 32'd434);
    check("rst_rdata", rdata_o, 32'd0);
    check("rst_rd_valid", 32'(rd_valid_o), 32'd0);
    check("rst_irq", 32'(irq_o), 32'd0);
    tick(2);
    rst = 1'b0;
    uart_rxd_i = 1'b1;
    host_rd(A_STAT, 32'h0000_0001);
    host_rd(A_CTRL, 32'h0);
    tick(20);
    check("rst_no_prog", 32'(bit_period_o), 32'd434);

    // basic capture and pops
    host_wr(A_CTRL, 32'h1);
    rx_byte(8'hA5, 1'b0);
    rx_byte(8'h3C, 1'b0);
    host_rd(A_STAT, 32'h0000_0200);
    host_rd(A_DATA, 32'h0000_00A5);
    host_rd(A_DATA, 32'h0000_003C);
    host_rd(A_DATA, 32'h8000_0000);

    // divisor change deferred until the line is quiet
    host_wr(A_DIV, 32'h1B2);
    host_rd(A_STAT, 32'h0000_0011);
    bad = 0;
    for (int i = 0; i < 3000; i++) begin
      uart_rxd_i = ((i % 10) != 9);
      tick();
      if (wr_bit_period_o || !rx_en_o) bad++;
    end
    check("toggle_no_prog", 32'(bad), 32'd0);
    uart_rxd_i = 1'b1;
    wait_pulse(n, bp);
    check("prog_delay", 32'(n), 32'd868);
    check("prog_value", 32'(bp), 32'h1B2);
    check("prog_rx_en", 32'(rx_en_o), 32'd0);
    @(negedge clk);
    check("resume_wr_bp", 32'(wr_bit_period_o), 32'd0);
    check("resume_rx_en", 32'(rx_en_o), 32'd0);
    @(negedge clk);
    check("run_rx_en", 32'(rx_en_o), 32'd1);
    check("bp_hold", 32'(bit_period_o), 32'h1B2);
    tick();
    host_rd(A_DIV, 32'h1B2);

    // overrun, W1C, push+pop while full
    for (int i = 0; i < 17; i++) rx_byte(8'h10 + 8'(i), 1'b0);
    host_rd(A_STAT, 32'h0000_1006);
    host_wr(A_STAT, 32'h4);
    host_rd(A_STAT, 32'h0000_1002);
    rx_data_i = 8'h99;
    rx_parity_error_i = 1'b0;
    rx_valid_i = 1'b1;
    rd_i = 1'b1;
    addr_i = A_DATA;
    exp_q.push_back(32'h10);
    tick();
    rx_valid_i = 1'b0;
    rd_i = 1'b0;
    tick();
    host_rd(A_STAT, 32'h0000_1002);
    for (int i = 1; i < 16; i++) host_rd(A_DATA, 32'h10 + 32'(i));
    host_rd(A_DATA, 32'h99);
    host_rd(A_DATA, 32'h8000_0000);

    // parity and level-held valid
    rx_byte(8'h5A, 1'b1);
    host_rd(A_DATA, 32'h0000_015A);
    host_rd(A_STAT, 32'h0000_0009);
    host_wr(A_STAT, 32'h8);
    host_rd(A_STAT, 32'h0000_0001);
    rx_data_i = 8'h77;
    rx_parity_error_i = 1'b0;
    rx_valid_i = 1'b1;
    tick(5);
    rx_valid_i = 1'b0;
    tick();
    host_rd(A_STAT, 32'h0000_0100);
    host_rd(A_DATA, 32'h77);

    // flush, including against a simultaneous push
    rx_byte(8'h01, 1'b0);
    rx_byte(8'h02, 1'b0);
    host_wr(A_CTRL, 32'h5);
    host_rd(A_STAT, 32'h0000_0001);
    rx_data_i = 8'h03;
    rx_valid_i = 1'b1;
    host_wr(A_CTRL, 32'h5);
    rx_valid_i = 1'b0;
    tick();
    host_rd(A_STAT, 32'h0000_0001);
    host_rd(A_CTRL, 32'h1);

    // divisor below the minimum
    host_wr(A_DIV, 32'h2);
    host_rd(A_DIV, 32'h4);
    wait_pulse(n, bp);
    check("min_div_seen", 32'(n >= 0), 32'd1);
    check("min_div_value", 32'(bp), 32'h4);
    tick(3);

    // interrupt
    host_wr(A_CTRL, 32'h0303);
    rx_byte(8'h31, 1'b0);
    rx_byte(8'h32, 1'b0);
    check("irq_below_thr", 32'(irq_o), 32'd0);
    rx_data_i = 8'h33;
    rx_valid_i = 1'b1;
    tick();
    rx_valid_i = 1'b0;
    @(negedge clk);
    check("irq_capture_cycle", 32'(irq_o), 32'd0);
    tick();
    @(negedge clk);
`ifdef UART_RX_CTRL_IRQ_EN
    check("irq_rise", 32'(irq_o), 32'd1);
    host_rd(A_CTRL, 32'h0303);
    host_rd(A_DATA, 32'h31);
    @(negedge clk);
    check("irq_pop_cycle", 32'(irq_o), 32'd1);
    tick();
    @(negedge clk);
    check("irq_fall", 32'(irq_o), 32'd0);
`else
    check("irq_off", 32'(irq_o), 32'd0);
    host_rd(A_CTRL, 32'h1);
    host_rd(A_STAT, 32'h0000_0300);
`endif
    tick(3);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
